// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, scoreboard flags, issue and
// write-back strobes, readiness and the debug tap. The pipeline side
// uses the master modport; the register file uses the slave modport.
interface regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [XLEN-1:0]   r1_data;
    logic [XLEN-1:0]   r2_data;
    logic              r1_busy;
    logic              r2_busy;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   wr_data;
    logic              ready;
    logic [XLEN-1:0]   out;

    modport master (
        output rs1, rs2, iss_en, iss_rd, wr_en, rd, wr_data,
        input  r1_data, r2_data, r1_busy, r2_busy, ready, out
    );

    modport slave (
        input  rs1, rs2, iss_en, iss_rd, wr_en, rd, wr_data,
        output r1_data, r2_data, r1_busy, r2_busy, ready, out
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register busy scoreboard
// for the pipelined RV32I core. Two combinational read ports, one
// synchronous write-back port, and a post-reset sequencer that zeroes one
// entry per cycle before the file reports ready.
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write-back data
// (and the cleared busy flag) onto the read ports.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;
    // Index of the last entry, widened to the counter width.
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    // One extra bit so the counter can step past the last index on the
    // transition cycle without wrapping back to zero.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;

    logic              ready;
    logic              wr_ok;
    logic              iss_ok;

    // Qualify strobes: ignored until ready, and index 0 is inert when hardwired.
    always_comb begin
        ready  = (state_q == RUN);
        wr_ok  = ready && bus.wr_en  && !((ZERO_REG != 0) && (bus.rd     == '0));
        iss_ok = ready && bus.iss_en && !((ZERO_REG != 0) && (bus.iss_rd == '0));
    end

    // Clear sequencer: walk every entry once, then hand over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = RUN;
            end
        end
    end

    // Per-entry next state. Issue is applied after write-back so that a
    // same-cycle issue to the same index leaves the register owned (busy).
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

        logic clr_hit;
        logic wr_hit;
        logic iss_hit;

        assign clr_hit = (state_q == INIT) && (cnt_q[ADDR_W-1:0] == IDX);
        assign wr_hit  = wr_ok  && (bus.rd     == IDX);
        assign iss_hit = iss_ok && (bus.iss_rd == IDX);

        assign regs_d[gi] = clr_hit ? '0 :
                            wr_hit  ? bus.wr_data : regs_q[gi];
        assign busy_d[gi] = iss_hit ? 1'b1 :
                            wr_hit  ? 1'b0 : busy_q[gi];
    end

    // Control state and scoreboard; reset wins over every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Data array has no reset; the sequencer clears it after rst drops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Combinational read ports, forced to zero until the clear completes.
    always_comb begin
        bus.r1_data = '0;
        bus.r2_data = '0;
        bus.r1_busy = 1'b0;
        bus.r2_busy = 1'b0;
        if (ready) begin
            bus.r1_data = ((ZERO_REG != 0) && (bus.rs1 == '0)) ? '0 : regs_q[bus.rs1];
            bus.r2_data = ((ZERO_REG != 0) && (bus.rs2 == '0)) ? '0 : regs_q[bus.rs2];
            bus.r1_busy = busy_q[bus.rs1];
            bus.r2_busy = busy_q[bus.rs2];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.rd == bus.rs1)) begin
                bus.r1_data = bus.wr_data;
                bus.r1_busy = iss_ok && (bus.iss_rd == bus.rs1);
            end
            if (wr_ok && (bus.rd == bus.rs2)) begin
                bus.r2_data = bus.wr_data;
                bus.r2_busy = iss_ok && (bus.iss_rd == bus.rs2);
            end
`endif
        end
    end

    assign bus.ready = ready;
    assign bus.out   = bus.wr_data;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor of the single-cycle integer register file, for the pipelined RV32I core.
- Two asynchronous read ports and one synchronous write-back port.
- Per-register busy scoreboard: decode marks a destination pending at issue; write-back clears it. Decode stalls on the busy flags.
- Post-reset clear sequencer zeroes the array one entry per cycle, so reset does not need a wide parallel clear.

Parameters:
XLEN, 32, data width of each register
ADDR_W, 5, register index width; NREGS = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 hardwired to zero and never busy; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rs1  in  ADDR_W  read port 1 index
rs2  in  ADDR_W  read port 2 index
r1_data  out  XLEN  read port 1 data (combinational)
r2_data  out  XLEN  read port 2 data (combinational)
r1_busy  out  1  scoreboard busy bit of rs1 (combinational)
r2_busy  out  1  scoreboard busy bit of rs2 (combinational)
iss_en  in  1  issue strobe: mark iss_rd pending
iss_rd  in  ADDR_W  destination index being issued
wr_en  in  1  write-back strobe
rd  in  ADDR_W  write-back index
wr_data  in  XLEN  write-back data
ready  out  1  high once the clear sequence has finished
out  out  XLEN  debug tap, equals wr_data combinationally

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. rst sampled high at a posedge gives:
  - state INIT, clear counter cnt=0;
  - all busy bits 0, ready=0.
  - rst has priority over every other input.
- FSM, two states: INIT and RUN.
  - INIT: one entry cleared per cycle (regs[cnt] <= 0, cnt <= cnt+1).
  - After clearing entry NREGS-1, move to RUN. ready=1 from the first RUN cycle, exactly NREGS cycles after rst deasserts.
  - rst asserted mid-INIT restarts cnt at 0.
  - cnt is ADDR_W+1 bits wide so the final index does not wrap before the transition.
- While ready=0:
  - wr_en and iss_en ignored;
  - r1_data, r2_data, r1_busy, r2_busy forced to 0.
- RUN write: wr_en=1 writes regs[rd] <= wr_data at the posedge and clears busy[rd] at the same posedge.
- RUN issue: iss_en=1 sets busy[iss_rd] at the posedge.
- Same-cycle issue and write-back to the same index: data is written, busy ends at 1 (the new producer owns the register).
- Read during same-cycle write, bypass off: returns the old value; the new value is visible from the next cycle.
- ZERO_REG=1:
  - writes to index 0 are discarded;
  - issue to index 0 does not set busy;
  - reads of index 0 return 0 and busy 0.
- ZERO_REG=0: index 0 behaves like any other entry.
- Write-back to a register that is not busy is legal: data is written, busy stays 0.
- out = wr_data in every state, including INIT.
- Latency: reads are 0 cycles; writes and scoreboard updates take effect 1 cycle after the posedge that samples them.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined, in RUN: when wr_en=1 and rd equals rs1 (or rs2), and the index is not a discarded zero-register write:
  - r1_data (or r2_data) returns wr_data combinationally in the same cycle;
  - r1_busy (or r2_busy) reads 0 unless iss_en=1 targets that same index in that cycle.
- Not defined: reads return the stored array value and busy reflects registered state only.
- Neither setting changes any registered state.

Test Plan:
- Reset sequence: pulse rst 1 cycle, then hold wr_en=1 with rd=3, wr_data=0xDEADBEEF throughout INIT -> ready rises exactly 32 cycles after rst falls; reading rs1=3 returns 0 (write ignored).
- Basic write/read in RUN: write rd=5, data 0x12345678 -> next cycle r1_data=0x12345678 with rs1=5. Write rd=0, data 0xFFFFFFFF -> r2_data=0 with rs2=0.
- Scoreboard: iss_en with iss_rd=7 -> r1_busy=1 next cycle for rs1=7; write-back rd=7, data 0xA5 -> r1_busy=0 and r1_data=0xA5 next cycle. Issue to index 0 -> busy stays 0.
- Simultaneous events: iss_rd=9 and rd=9 in the same cycle with data 0x55 -> next cycle busy=1 and data=0x55.
- Bypass: rd=rs1=4, wr_data=0x77, old value 0x11. Built with REGFILE_BYPASS_EN -> r1_data=0x77 in the same cycle. Built without -> 0x11, then 0x77 next cycle.
- Mid-INIT reset: assert rst at INIT cycle 10 -> cnt restarts; ready rises 32 cycles after the second rst falls; all 32 entries read 0.
